// File: rtl/fifo_stream_reader_if.sv
// Stream side of fifo_stream_reader: valid/ready beats with packet framing.
//   m_valid : beat available (driven by master)
//   m_ready : consumer accepts the beat (driven by slave)
//   m_data  : beat payload, WIDTH bits
//   m_last  : final beat of the current packet
interface fifo_stream_reader_if #(
  parameter int WIDTH = 4
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a one-cycle-latency FIFO (registered dout) into a
// valid/ready stream, tagging every burst_len+1-th beat with m_last.
// A 2-entry output buffer plus one in-flight read form a credit loop that
// sustains one beat per clock and never drops a beat under backpressure.
//
// Ports:
//   clk, rst_n    clock, async active-low reset (shared with the FIFO)
//   fifo_rden     FIFO read strobe (combinational, never while fifo_empty)
//   fifo_dout     FIFO read data, valid the cycle after fifo_rden
//   fifo_empty    FIFO empty flag
//   fifo_counter  FIFO occupancy
//   burst_len     packet length minus 1, sampled at each packet's start
//   m             stream master (m_valid/m_data/m_last registered, m_ready in)
//
// Optional feature macro: FIFO_RD_WAIT_FULL_BURST_EN
//   When defined, reads for a packet start only once the FIFO holds the whole
//   packet, so a packet never has internal gaps from FIFO underrun.
module fifo_stream_reader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fifo_rden,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  input  logic [$clog2(DEPTH):0] fifo_counter,
  input  logic [LEN_W-1:0]       burst_len,
  fifo_stream_reader_if.master   m
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t [1:0]      buf_q, buf_d;
  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_last_q;
  logic [LEN_W-1:0] rd_cnt_q, len_q, len_eff;
  logic             pop, issue_en, len_ld, last_tag;
  logic [2:0]       credit;

  assign pop       = m.m_valid & m.m_ready;
  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = buf_q[0].data;
  assign m.m_last  = buf_q[0].last;

  // Slots committed after this cycle; pop implies occ_q >= 1, so no underflow.
  assign credit    = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign fifo_rden = !fifo_empty & issue_en & (credit < 3'd2);
  assign last_tag  = (rd_cnt_q == len_eff);

  // Shift on pop first, then land the in-flight word in the first free slot.
  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
    end
    if (infl_q) begin
      buf_d[occ_d[0]] = {fifo_dout, infl_last_q};
      occ_d           = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      occ_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      rd_cnt_q    <= '0;
      len_q       <= '0;
    end else begin
      buf_q  <= buf_d;
      occ_q  <= occ_d;
      infl_q <= fifo_rden;
      if (fifo_rden) begin
        infl_last_q <= last_tag;
        rd_cnt_q    <= last_tag ? '0 : rd_cnt_q + LEN_W'(1);
      end
      if (len_ld) len_q <= burst_len;
    end
  end

`ifdef FIFO_RD_WAIT_FULL_BURST_EN
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t         state_q, state_d;
  logic [LEN_W:0] need;

  // Packet length is latched on the IDLE->BURST decision so the gate and the
  // framing agree even if burst_len moves before the first read.
  assign need     = {1'b0, burst_len} + (LEN_W+1)'(1);
  assign issue_en = (state_q == S_BURST);
  assign len_eff  = len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    len_ld  = 1'b0;
    case (state_q)
      S_IDLE:
        if (rd_cnt_q == '0 && (LEN_W+1)'(fifo_counter) >= need) begin
          state_d = S_BURST;
          len_ld  = 1'b1;
        end
      S_BURST:
        if (fifo_rden && last_tag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
`else
  logic unused_counter;
  assign unused_counter = ^fifo_counter;
  assign issue_en = 1'b1;
  // First beat of a packet frames against the live burst_len being latched.
  assign len_eff  = (rd_cnt_q == '0) ? burst_len : len_q;
  assign len_ld   = fifo_rden & (rd_cnt_q == '0);
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A behavioural one-cycle-latency
// FIFO feeds the DUT; expected beats (data + last) come from a queue filled
// from the packet-length rules as words are written.
module tb_fifo_stream_reader;
`ifdef FIFO_RD_WAIT_FULL_BURST_EN
  localparam int LAT = 3;
  localparam int GAP = 2;
`else
  localparam int LAT = 2;
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_rden;
  logic [3:0] fifo_dout;
  logic       fifo_empty;
  logic [4:0] fifo_counter;
  logic [7:0] burst_len;

  fifo_stream_reader_if #(.WIDTH(4)) sv ();

  fifo_stream_reader #(.WIDTH(4), .DEPTH(16), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rden(fifo_rden), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_counter(fifo_counter),
    .burst_len(burst_len), .m(sv)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: writes from the stimulus, reads on fifo_rden.
  logic [3:0] mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rden_viol = 0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_counter = 5'(wr_ptr - rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_dout <= '0;
    else if (fifo_rden) begin
      if (wr_ptr == rd_ptr) rden_viol <= rden_viol + 1;
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
  endtask

  // n words start, start+1, ... with packets of blen+1 beats, aligned at word 0.
  task automatic fill(input int n, input logic [3:0] start, input int blen);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = 4'(start + 4'(i));
      wr(d);
      exp_q.push_back({d, (i % (blen + 1)) == blen});
    end
  endtask

  // Consume n beats with m_ready=1; first beat may take first_lat cycles,
  // later beats at most gap idle cycles each.
  task automatic expect_stream(input string tag, input int n, input int first_lat, input int gap);
    logic [4:0] e;
    int w, lim;
    for (int i = 0; i < n; i++) begin
      w   = 0;
      lim = (i == 0) ? first_lat : gap;
      while (!sv.m_valid && w < lim) begin @(negedge clk); w++; end
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, sv.m_valid}, 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1f;
      chk($sformatf("%s_data%0d", tag, i), {28'd0, sv.m_data}, {28'd0, e[4:1]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, sv.m_last}, {31'd0, e[0]});
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4:0] e;
    logic [3:0] d;
    int base, nw, pos;
    rst_n = 1'b0;
    sv.m_ready = 1'b0;
    burst_len = 8'd3;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, sv.m_valid}, 32'd0);
    chk("rst_data",  {28'd0, sv.m_data},  32'd0);
    chk("rst_last",  {31'd0, sv.m_last},  32'd0);
    chk("rst_rden",  {31'd0, fifo_rden},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming: 8 words, burst_len=3, first beat exactly LAT cycles after write.
    sv.m_ready = 1'b1;
    fill(8, 4'h1, 3);
    @(negedge clk);
    chk("str_early", {31'd0, sv.m_valid}, 32'd0);
    expect_stream("str", 8, LAT - 1, GAP);

    // Backpressure: only two reads while stalled, head beat held stable.
    sv.m_ready = 1'b0;
    base = rd_ptr;
    fill(8, 4'h1, 3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk($sformatf("bp_hold_v%0d", k), {31'd0, sv.m_valid}, 32'd1);
        chk($sformatf("bp_hold_d%0d", k), {28'd0, sv.m_data}, 32'd1);
      end
    end
    chk("bp_reads", rd_ptr - base, 32'd2);
    sv.m_ready = 1'b1;
    expect_stream("bp", 8, 0, GAP);

    // burst_len=0: every beat is its own packet.
    burst_len = 8'd0;
    fill(4, 4'h5, 0);
    expect_stream("b0", 4, LAT, GAP);

    // burst_len 3 -> 1 after beat 2: first packet stays 4 beats, then 2-beat packets.
    burst_len = 8'd3;
    for (int i = 0; i < 8; i++) begin
      d = 4'(4'h8 + 4'(i));
      wr(d);
      exp_q.push_back({d, (i == 3) || (i == 5) || (i == 7)});
    end
    expect_stream("chg_a", 2, LAT, GAP);
    burst_len = 8'd1;
    expect_stream("chg_b", 6, GAP, GAP);

    // Random ready, 256 random words, burst_len=7.
    burst_len = 8'd7;
    nw = 0;
    pos = 0;
    for (int cyc = 0; cyc < 6000 && (nw < 256 || exp_q.size() != 0); cyc++) begin
      @(negedge clk);
      sv.m_ready = 1'($urandom_range(0, 1));
      if (sv.m_valid && sv.m_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1f;
        chk("rnd_data", {28'd0, sv.m_data}, {28'd0, e[4:1]});
        chk("rnd_last", {31'd0, sv.m_last}, {31'd0, e[0]});
      end
      if (nw < 256 && (wr_ptr - rd_ptr) < 16 && $urandom_range(0, 1) == 1) begin
        d = 4'($urandom_range(0, 15));
        wr(d);
        exp_q.push_back({d, pos == 7});
        pos = (pos + 1) % 8;
        nw++;
      end
    end
    chk("rnd_drained", exp_q.size(), 32'd0);
    chk("rnd_rden_empty", rden_viol, 32'd0);
    sv.m_ready = 1'b1;
    repeat (4) @(negedge clk);

`ifdef FIFO_RD_WAIT_FULL_BURST_EN
    // Full-burst gate: nothing read until the whole packet is present.
    burst_len = 8'd3;
    base = rd_ptr;
    for (int i = 0; i < 3; i++) begin
      wr(4'(4'h2 + 4'(i)));
      exp_q.push_back({4'(4'h2 + 4'(i)), 1'b0});
    end
    repeat (6) @(negedge clk);
    chk("mac_noread", rd_ptr - base, 32'd0);
    chk("mac_novalid", {31'd0, sv.m_valid}, 32'd0);
    wr(4'h5);
    exp_q.push_back({4'h5, 1'b1});
    expect_stream("mac", 4, 3, 0);
`endif

    // Reset mid-packet with both buffer slots full.
    burst_len = 8'd1;
    sv.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(4'(4'h1 + 4'(i)));
    for (int w = 0; w < 6 && !sv.m_valid; w++) @(negedge clk);
    sv.m_ready = 1'b1;
    @(negedge clk);
    sv.m_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_data", {28'd0, sv.m_data}, 32'd2);
    chk("pre_rst_last", {31'd0, sv.m_last}, 32'd1);
    rst_n = 1'b0;
    wr_ptr = rd_ptr;
    #1;
    chk("mid_rst_valid", {31'd0, sv.m_valid}, 32'd0);
    chk("mid_rst_data",  {28'd0, sv.m_data},  32'd0);
    chk("mid_rst_last",  {31'd0, sv.m_last},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    burst_len = 8'd3;
    sv.m_ready = 1'b1;
    fill(8, 4'h9, 3);
    expect_stream("post_rst", 8, LAT, GAP);
    chk("final_rden_empty", rden_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the single-clock FIFO: drains a FIFO with a registered `dout` and one-cycle read latency, and presents the data as a valid/ready stream with packet framing. The block issues `fifo_rden` under a two-entry credit scheme to sustain one beat per cycle with no data loss under backpressure. It tags every `burst_len+1`-th beat with `m_last`. It sits between a `sync_fifo` instance and any stream consumer, such as a DMA or AXI write-data channel.

## Interface
- `WIDTH`, default 4: data width. Must match the FIFO's `WIDTH`.
- `DEPTH`, default 16: FIFO depth. Sets the `fifo_counter` width to `CLOG2(DEPTH)+1`.
- `LEN_W`, default 8: width of `burst_len` and of the internal beat counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low. Shared with the FIFO.
- `fifo_rden`  out  1  FIFO read strobe. Combinational, never asserted while `fifo_empty`=1.
- `fifo_dout`  in  WIDTH  FIFO read data. Valid in the cycle after `fifo_rden`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_counter`  in  CLOG2(DEPTH)+1  FIFO occupancy.
- `burst_len`  in  LEN_W  packet length minus 1. Sampled at each packet's first read.
- `m_valid`  out  1  stream valid. Registered.
- `m_ready`  in  1  stream ready.
- `m_data`  out  WIDTH  stream data. Registered.
- `m_last`  out  1  last beat of packet. Registered.

## Operation
- Output buffer: 2 entries, each holding `{data, last}`. Entry 0 drives `m_data`/`m_last`, and `m_valid` = (occupancy ≠ 0).
- `pop` = `m_valid & m_ready`. On a pop, entry 1 shifts to entry 0.
- In-flight register: `infl` = `fifo_rden` delayed 1 cycle, plus `infl_last`. When `infl`=1, `fifo_dout` is pushed into the first free slot after any shift.
- Credit rule: `fifo_rden` = `!fifo_empty & issue_en & (occ + infl - pop < 2)`. This gives 1 beat/cycle in steady state: occ=1, infl=1, pop=1.
- Issue-side counter `rd_cnt` (LEN_W bits):
  - On each read with `rd_cnt`=0, latch `len_q` = `burst_len`.
  - Tag `infl_last` = (`rd_cnt == len_q`), using the just-latched value on the first beat.
  - Then `rd_cnt` ← 0 if last, else `rd_cnt`+1.
- `burst_len`=0: every beat carries `m_last`. Changes to `burst_len` mid-packet are ignored until the next packet.
- Without the macro (see Configuration), `issue_en`=1 constantly.
- Simultaneous push and pop: occupancy is unchanged and order is preserved.
- Stall: with `m_ready`=0, at most 2 beats are accepted, reads stop, and no beat is dropped or duplicated.
- `m_data`/`m_last` stay stable while `m_valid & !m_ready`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `fifo_rden`=0, occ=0, `infl`=0, `rd_cnt`=0, `len_q`=0. State S_IDLE when the macro is defined.
- Latency:
  - `fifo_rden` at cycle N gives `fifo_dout` at N+1, captured at the end of N+1, so `m_valid` rises at N+2 if the buffer was empty.
  - First word: `fifo_empty` falls at cycle T, `m_valid` rises at T+2.
- Throughput: 1 beat/clk with `m_ready`=1 and the FIFO non-empty.
- `m_ready` rising after a stall with occ=2: beats are back-to-back and reads resume in the same cycle.
- Reset mid-packet: the buffer and in-flight beat are discarded, framing restarts at beat 0, and the FIFO is cleared by the same `rst_n`.

## Configuration
- Macro `FIFO_RD_WAIT_FULL_BURST_EN`.
- Defined: issue is gated by a 2-state FSM.
  - S_IDLE: `issue_en`=0. Go to S_BURST when `rd_cnt`=0 and `fifo_counter >= burst_len+1`. This comparison is done in LEN_W+1 bits, and the value of `burst_len` used is latched into `len_q`.
  - S_BURST: `issue_en`=1. Return to S_IDLE in the cycle after issuing the read tagged last.
  - Effect: no gaps inside a packet caused by FIFO underrun.
- Not defined: the FSM is absent, and reads issue whenever the FIFO is non-empty and credit allows.

## Test plan
- Streaming: write 0x1..0x8 into the FIFO, `m_ready`=1, `burst_len`=3 → `m_data` 0x1..0x8 on 8 consecutive cycles starting 2 cycles after empty falls. `m_last` on 0x4 and 0x8.
- Backpressure: 8 words in the FIFO, `m_ready`=0 for 10 cycles → exactly 2 reads issued, `m_data`=0x1 held stable. Then `m_ready`=1 → 0x1..0x8 in order, no bubbles.
- Random `m_ready` (50%) over 256 words, `burst_len`=7 → in-order data, `m_last` every 8th accepted beat, `fifo_rden` never asserted while empty.
- `burst_len`=0 → `m_last`=1 on every beat. Change `burst_len` from 3 to 1 after beat 2 → the current packet still ends at beat 4, and the next packet is 2 beats.
- Macro defined, `burst_len`=3: write 3 words → no `fifo_rden`. Write the 4th word → 4 back-to-back beats with `m_valid` never dropping mid-packet.
- Assert `rst_n` low mid-packet with occ=2 → `m_valid`/`m_last`/`m_data` = 0 immediately. After release, the next packet's `m_last` falls on beat `burst_len+1`.
